datapath_core: RTL

- Accumulator datapath that sits at the other end of the multi-cycle controller's control/status interface.
- Executes the micro-operations commanded by control lines c0..c14 (c6 does not exist).
- Returns opcode-decode and flag status lines s0..s10 to the controller.
- Contains PC, MAR, MDR, IR, ACC, Z/C flags and a small synchronous RAM with a bench preload port.

---
 rtl/datapath_core.sv | 89 ++++++++
 1 files changed

// File: rtl/datapath_core.sv
// datapath_core: accumulator datapath executing controller micro-ops and returning decode/flag status
module datapath_core #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          c0,
  input  logic          c1,
  input  logic          c2,
  input  logic          c3,
  input  logic          c4,
  input  logic          c5,
  input  logic          c7,
  input  logic          c8,
  input  logic          c9,
  input  logic          c10,
  input  logic          c11,
  input  logic          c12,
  input  logic          c13,
  input  logic          c14,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          s0,
  output logic          s1,
  output logic          s2,
  output logic          s3,
  output logic          s4,
  output logic          s5,
  output logic          s6,
  output logic          s7,
  output logic          s8,
  output logic          s9,
  output logic          s10,
  output logic [DW-1:0] acc_out,
  output logic [AW-1:0] pc_out
);
  logic [AW-1:0] r_pc, r_mar;
  logic [DW-1:0] r_mdr, r_ir, r_acc;
  logic          r_z, r_c;
  logic [DW-1:0] r_mem [0:2**AW-1];
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_acc_next;
  logic [AW-1:0] w_wa;
  logic [2:0]    w_op;
  logic          w_unused;
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_mdr};
  assign w_acc_next = c0 ? '0 : c13 ? r_mdr : c9 ? w_sum[DW-1:0] : c8 ? r_acc + DW'(1) : r_acc;
  assign w_wa       = c12 ? r_ir[AW-1:0] : r_mar;
  assign w_op       = r_ir[DW-1 -: 3];
  assign w_unused   = ^r_ir;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_pc  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      r_pc  <= c0 ? '0 : c1 ? r_ir[AW-1:0] : c2 ? r_pc + AW'(1) : r_pc;
      r_mar <= c14 ? r_mdr[AW-1:0] : c12 ? r_ir[AW-1:0] : c3 ? r_pc : r_mar;
      r_mdr <= c4 ? r_mem[r_mar] : c5 ? r_mdr + DW'(1) : r_mdr;
      r_ir  <= c0 ? '0 : c7 ? r_mdr : r_ir;
      r_acc <= w_acc_next;
      if (c10) begin
        r_z <= w_acc_next == '0;
        r_c <= c9 & w_sum[DW];
      end
    end
  always_ff @(posedge CLK)
    if (ld_en) r_mem[ld_addr] <= ld_data;
    else if (c11) r_mem[w_wa] <= r_acc;
  assign s0      = w_op == 3'd0;
  assign s1      = w_op == 3'd1;
  assign s2      = w_op == 3'd2;
  assign s3      = w_op == 3'd3;
  assign s4      = w_op == 3'd4;
  assign s5      = w_op == 3'd5;
  assign s6      = w_op == 3'd6;
  assign s7      = w_op == 3'd7;
  assign s8      = r_z;
  assign s9      = r_c;
  assign s10     = &r_pc;
  assign acc_out = r_acc;
  assign pc_out  = r_pc;
endmodule
